// File: rtl/main_memory.sv
// main_memory: handshaked memory model with byte-enabled single-word writes,
// aligned burst reads of one cache line, and a fixed access latency.
module main_memory #(
  parameter int DATA_W       = 32,
  parameter int DEPTH_LOG2   = 10,
  parameter int ADDR_W       = 29,
  parameter int LATENCY      = 3,
  parameter int BURST_LOG2   = 2,
  parameter int INIT_PATTERN = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_we,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [DATA_W-1:0]   i_req_wdata,
  input  logic [DATA_W/8-1:0] i_req_be,
  output logic                o_resp_valid,
  input  logic                i_resp_ready,
  output logic [DATA_W-1:0]   o_resp_rdata,
  output logic                o_resp_last
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int BYTES  = DATA_W / 8;
  localparam int BL     = 1 << BURST_LOG2;
  localparam int LAT_W  = $clog2(LATENCY + 1);
  localparam int BEAT_W = (BURST_LOG2 > 0) ? BURST_LOG2 : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RBURST,
    S_WACK
  } state_t;

  state_t              r_state;
  logic [LAT_W-1:0]    r_latCnt;
  logic [BEAT_W-1:0]   r_beat;
  logic                r_we;
  logic [DEPTH_LOG2-1:0] r_index;
  logic [DATA_W-1:0]   r_wdata;
  logic [BYTES-1:0]    r_be;
  logic                r_reqReady;
  logic                r_respValid;
  logic                r_respLast;
  logic [DATA_W-1:0]   r_respRdata;

  logic [DATA_W-1:0]     w_mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] w_base;
  logic [BEAT_W-1:0]     w_nextBeat;
  logic [DEPTH_LOG2-1:0] w_nextIdx;
  logic                  w_lastBeat;
  logic                  w_commit;
  logic                  w_unusedAddrBits;

  // Upper address bits select nothing: the array aliases across them.
  assign w_unusedAddrBits = ^i_req_addr[ADDR_W-1:DEPTH_LOG2];

  assign w_base     = r_index & ~DEPTH_LOG2'(BL - 1);
  assign w_nextBeat = r_beat + BEAT_W'(1);
  assign w_nextIdx  = w_base + DEPTH_LOG2'(w_nextBeat);
  assign w_lastBeat = (r_beat == BEAT_W'(BL - 1));
  assign w_commit   = i_rst_n && (r_state == S_WAIT) && (r_latCnt == '0) && r_we;

  assign o_req_ready  = r_reqReady;
  assign o_resp_valid = r_respValid;
  assign o_resp_rdata = r_respRdata;
  assign o_resp_last  = r_respLast;

  // Storage: one register per word so each carries its own power-up value.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    localparam logic [DATA_W-1:0] INIT_VAL =
      (INIT_PATTERN != 0) ? DATA_W'(gi % 16) : {DATA_W{1'bx}};
    logic [DATA_W-1:0] r_word = INIT_VAL;

    // Merge the enabled bytes of the latched write when its latency expires.
    always_ff @(posedge i_clk) begin
      if (w_commit && (r_index == DEPTH_LOG2'(gi))) begin
        for (int b = 0; b < BYTES; b++) begin
          if (r_be[b]) r_word[8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end

    assign w_mem[gi] = r_word;
  end

  // Request/response sequencer with registered handshake and data outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_latCnt    <= '0;
      r_beat      <= '0;
      r_we        <= 1'b0;
      r_index     <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_reqReady  <= 1'b0;
      r_respValid <= 1'b0;
      r_respLast  <= 1'b0;
      r_respRdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_reqReady <= 1'b1;
          if (i_req_valid && r_reqReady) begin
            r_we       <= i_req_we;
            r_index    <= i_req_addr[DEPTH_LOG2-1:0];
            r_wdata    <= i_req_wdata;
            r_be       <= i_req_be;
            r_latCnt   <= LAT_W'(LATENCY - 1);
            r_reqReady <= 1'b0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_latCnt == '0) begin
            r_beat      <= '0;
            r_respValid <= 1'b1;
            if (r_we) begin
              r_respLast  <= 1'b1;
              r_respRdata <= '0;
              r_state     <= S_WACK;
            end else begin
              r_respLast  <= (BL == 1);
              r_respRdata <= w_mem[w_base];
              r_state     <= S_RBURST;
            end
          end else begin
            r_latCnt <= r_latCnt - LAT_W'(1);
          end
        end
        S_RBURST: begin
          if (i_resp_ready) begin
            if (w_lastBeat) begin
              r_respValid <= 1'b0;
              r_respLast  <= 1'b0;
              r_respRdata <= '0;
              r_reqReady  <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_beat      <= w_nextBeat;
              r_respRdata <= w_mem[w_nextIdx];
              r_respLast  <= (w_nextBeat == BEAT_W'(BL - 1));
            end
          end
        end
        S_WACK: begin
          if (i_resp_ready) begin
            r_respValid <= 1'b0;
            r_respLast  <= 1'b0;
            r_reqReady  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory.sv
// Testbench for main_memory: vector table, reset/backpressure sequences and
// randomized traffic checked against a plain word-array model.
module tb_main_memory;

  localparam int DATA_W     = 32;
  localparam int DEPTH_LOG2 = 10;
  localparam int ADDR_W     = 29;
  localparam int LATENCY    = 3;
  localparam int BURST_LOG2 = 2;
  localparam int BL         = 1 << BURST_LOG2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  typedef logic [BL-1:0][DATA_W-1:0] beats_t;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        be;
    beats_t            exp;
  } vec_t;

  logic              clk = 1'b0;
  logic              i_rst_n;
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_we;
  logic [ADDR_W-1:0] i_req_addr;
  logic [DATA_W-1:0] i_req_wdata;
  logic [3:0]        i_req_be;
  logic              o_resp_valid;
  logic              i_resp_ready;
  logic [DATA_W-1:0] o_resp_rdata;
  logic              o_resp_last;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] model [DEPTH];
  vec_t vecs [12];

  main_memory #(
    .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .ADDR_W(ADDR_W),
    .LATENCY(LATENCY), .BURST_LOG2(BURST_LOG2), .INIT_PATTERN(1)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_addr(i_req_addr),
    .i_req_wdata(i_req_wdata), .i_req_be(i_req_be),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_rdata(o_resp_rdata), .o_resp_last(o_resp_last)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkQuiet(input string name);
    checkOutput({name, ".req_ready"}, o_req_ready, 0);
    checkOutput({name, ".resp_valid"}, o_resp_valid, 0);
    checkOutput({name, ".resp_last"}, o_resp_last, 0);
    checkOutput({name, ".resp_rdata"}, o_resp_rdata, 0);
  endtask

  function automatic beats_t beats4(input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] c, input logic [31:0] d);
    beats_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  function automatic void modelWrite(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                                     input logic [3:0] be);
    int idx;
    idx = int'(addr) % DEPTH;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) model[idx][8*k +: 8] = data[8*k +: 8];
    end
  endfunction

  function automatic beats_t modelBurst(input logic [ADDR_W-1:0] addr);
    beats_t r;
    int base;
    base = ((int'(addr) % DEPTH) / BL) * BL;
    for (int k = 0; k < BL; k++) r[k] = model[(base + k) % DEPTH];
    return r;
  endfunction

  // One complete transaction: exact latency, per-beat data/last, and
  // resp_ready driven low in response cycles whose stallMask bit is set.
  task automatic applyStimulus(input string name, input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input beats_t exp, input logic [31:0] stallMask);
    int nBeats;
    int beat;
    int cyc;
    logic hs;
    nBeats = we ? 1 : BL;
    beat = 0;
    cyc = 0;
    checkOutput({name, ".ready_idle"}, o_req_ready, 1);
    i_req_valid  = 1'b1;
    i_req_we     = we;
    i_req_addr   = addr;
    i_req_wdata  = wdata;
    i_req_be     = be;
    i_resp_ready = !stallMask[0];
    tick();
    i_req_valid = 1'b0;
    i_req_wdata = $urandom;
    i_req_addr  = ADDR_W'($urandom);
    checkOutput({name, ".ready_busy"}, o_req_ready, 0);
    checkOutput({name, ".early_valid0"}, o_resp_valid, 0);
    for (int c = 1; c < LATENCY; c++) begin
      tick();
      checkOutput($sformatf("%s.early_valid%0d", name, c), o_resp_valid, 0);
    end
    tick();
    while (beat < nBeats && cyc < 64) begin
      checkOutput($sformatf("%s.valid_c%0d", name, cyc), o_resp_valid, 1);
      checkOutput($sformatf("%s.data_b%0d", name, beat), o_resp_rdata, exp[beat]);
      checkOutput($sformatf("%s.last_b%0d", name, beat), o_resp_last, (beat == nBeats - 1));
      hs = i_resp_ready;
      tick();
      if (hs) beat++;
      cyc++;
      i_resp_ready = (cyc < 32) ? !stallMask[cyc] : 1'b1;
    end
    checkOutput({name, ".beats_done"}, beat, nBeats);
    checkOutput({name, ".ready_after"}, o_req_ready, 1);
    checkOutput({name, ".valid_after"}, o_resp_valid, 0);
    i_resp_ready = 1'b1;
    if (we) modelWrite(addr, wdata, be);
  endtask

  // Hard stop in case anything in the sequence stalls unexpectedly.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, vector table, corner sequences, random traffic.
  initial begin
    logic [ADDR_W-1:0] ra;
    logic [3:0]        rbe;
    logic [31:0]       rdata;
    logic [31:0]       rmask;
    logic              rwe;
    beats_t            rexp;

    for (int i = 0; i < DEPTH; i++) model[i] = 32'(i % 16);

    vecs[0]  = '{1'b0, 29'h13,        32'h0,        4'h0, beats4(32'h0, 32'h1, 32'h2, 32'h3)};
    vecs[1]  = '{1'b1, 29'h5,         32'hAABBCCDD, 4'h5, beats4(32'h0, 32'h0, 32'h0, 32'h0)};
    vecs[2]  = '{1'b0, 29'h4,         32'h0,        4'h0, beats4(32'h4, 32'h00BB00DD, 32'h6, 32'h7)};
    vecs[3]  = '{1'b0, 29'h1FFFFFFE,  32'h0,        4'h0, beats4(32'hC, 32'hD, 32'hE, 32'hF)};
    vecs[4]  = '{1'b1, 29'h22,        32'h12345678, 4'h0, beats4(32'h0, 32'h0, 32'h0, 32'h0)};
    vecs[5]  = '{1'b0, 29'h21,        32'h0,        4'h0, beats4(32'h0, 32'h1, 32'h2, 32'h3)};
    vecs[6]  = '{1'b1, 29'h47,        32'hDEADBEEF, 4'hF, beats4(32'h0, 32'h0, 32'h0, 32'h0)};
    vecs[7]  = '{1'b0, 29'h44,        32'h0,        4'h0, beats4(32'h4, 32'h5, 32'h6, 32'hDEADBEEF)};
    vecs[8]  = '{1'b1, 29'h401,       32'hCAFEBABE, 4'hC, beats4(32'h0, 32'h0, 32'h0, 32'h0)};
    vecs[9]  = '{1'b0, 29'h10000002,  32'h0,        4'h0, beats4(32'h0, 32'hCAFE0001, 32'h2, 32'h3)};
    vecs[10] = '{1'b1, 29'h7,         32'h0000AB00, 4'h2, beats4(32'h0, 32'h0, 32'h0, 32'h0)};
    vecs[11] = '{1'b0, 29'h5,         32'h0,        4'h0, beats4(32'h4, 32'h00BB00DD, 32'h6, 32'h0000AB07)};

    i_rst_n      = 1'b0;
    i_req_valid  = 1'b0;
    i_req_we     = 1'b0;
    i_req_addr   = '0;
    i_req_wdata  = '0;
    i_req_be     = '0;
    i_resp_ready = 1'b1;

    tick();
    checkQuiet("reset_c1");
    tick();
    checkQuiet("reset_c2");
    i_rst_n = 1'b1;
    tick();
    checkOutput("reset_release.req_ready", o_req_ready, 1);
    checkOutput("reset_release.resp_valid", o_resp_valid, 0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].be, vecs[i].exp, 32'h0);
    end

    applyStimulus("backpressure", 1'b0, 29'h33, 32'h0, 4'h0,
                  beats4(32'h0, 32'h1, 32'h2, 32'h3), 32'h0000001C);

    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 29'h9;
    i_req_wdata = 32'hFFFFFFFF; i_req_be = 4'hF;
    tick();
    i_req_valid = 1'b0;
    i_rst_n = 1'b0;
    tick();
    checkQuiet("rst_wait");
    i_rst_n = 1'b1;
    tick();
    checkOutput("rst_wait.release_ready", o_req_ready, 1);
    applyStimulus("rst_wait_read", 1'b0, 29'h8, 32'h0, 4'h0,
                  beats4(32'h8, 32'h9, 32'hA, 32'hB), 32'h0);

    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 29'h6A;
    i_resp_ready = 1'b0;
    tick();
    i_req_valid = 1'b0;
    for (int c = 1; c <= LATENCY; c++) tick();
    checkOutput("rst_burst.valid", o_resp_valid, 1);
    checkOutput("rst_burst.data", o_resp_rdata, 32'h8);
    tick();
    checkOutput("rst_burst.held_data", o_resp_rdata, 32'h8);
    i_rst_n = 1'b0;
    tick();
    checkQuiet("rst_burst");
    i_rst_n = 1'b1;
    i_resp_ready = 1'b1;
    tick();
    checkOutput("rst_burst.release_ready", o_req_ready, 1);
    applyStimulus("rst_burst_read", 1'b0, 29'h6B, 32'h0, 4'h0,
                  beats4(32'h8, 32'h9, 32'hA, 32'hB), 32'h0);

    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 29'h51;
    i_req_wdata = 32'h11223344; i_req_be = 4'hF;
    i_resp_ready = 1'b0;
    tick();
    i_req_valid = 1'b0;
    for (int c = 1; c <= LATENCY; c++) tick();
    checkOutput("rst_wack.valid", o_resp_valid, 1);
    checkOutput("rst_wack.last", o_resp_last, 1);
    checkOutput("rst_wack.data", o_resp_rdata, 32'h0);
    i_rst_n = 1'b0;
    tick();
    checkQuiet("rst_wack");
    i_rst_n = 1'b1;
    i_resp_ready = 1'b1;
    tick();
    modelWrite(29'h51, 32'h11223344, 4'hF);
    applyStimulus("rst_wack_read", 1'b0, 29'h50, 32'h0, 4'h0,
                  beats4(32'h0, 32'h11223344, 32'h2, 32'h3), 32'h0);

    for (int t = 0; t < 60; t++) begin
      rwe   = 1'($urandom_range(0, 1));
      ra    = ADDR_W'($urandom);
      ra[DEPTH_LOG2-1:0] = DEPTH_LOG2'($urandom_range(0, 63));
      rdata = $urandom;
      rbe   = 4'($urandom);
      rmask = ($urandom_range(0, 1) == 1) ? ($urandom & $urandom & 32'hFF) : 32'h0;
      rexp  = rwe ? '0 : modelBurst(ra);
      applyStimulus($sformatf("rand%0d", t), rwe, ra, rdata, rbe, rexp, rmask);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
